// File: rtl/rtype_pkg.sv
// rtype_pkg
// Shared definitions for the R-format execute stage:
//   - funct3 / funct7 encodings of the RV32I R-type instructions
//   - op_e     : decoded operation, including an explicit illegal marker
//   - state_e  : occupancy of the single-entry pipeline register
//   - decode_op: maps a funct3/funct7 pair onto op_e
package rtype_pkg;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_SLL,
    OP_SLT,
    OP_SLTU,
    OP_XOR,
    OP_SRL,
    OP_SRA,
    OP_OR,
    OP_AND,
    OP_ILLEGAL
  } op_e;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } state_e;

  // Only funct7 = BASE (all funct3) and funct7 = ALT (SUB/SRA) are legal;
  // everything else collapses to OP_ILLEGAL.
  function automatic op_e decode_op(input logic [2:0] f3, input logic [6:0] f7);
    op_e op;
    op = OP_ILLEGAL;
    if (f7 == F7_BASE) begin
      case (f3)
        F3_ADD_SUB: op = OP_ADD;
        F3_SLL:     op = OP_SLL;
        F3_SLT:     op = OP_SLT;
        F3_SLTU:    op = OP_SLTU;
        F3_XOR:     op = OP_XOR;
        F3_SRL_SRA: op = OP_SRL;
        F3_OR:      op = OP_OR;
        default:    op = OP_AND;
      endcase
    end else if (f7 == F7_ALT) begin
      if (f3 == F3_ADD_SUB) begin
        op = OP_SUB;
      end else if (f3 == F3_SRL_SRA) begin
        op = OP_SRA;
      end
    end
    return op;
  endfunction

endpackage

// File: rtl/and32_unit.sv
// and32_unit
// Shared 32-bit bitwise AND unit used by the datapath.
// Ports:
//   i_a, i_b : operands
//   o_y      : i_a & i_b
module and32_unit (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y
);

  assign o_y = i_a & i_b;

endmodule

// File: rtl/or32_unit.sv
// or32_unit
// Shared 32-bit bitwise OR unit used by the datapath.
// Ports:
//   i_a, i_b : operands
//   o_y      : i_a | i_b
module or32_unit (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y
);

  assign o_y = i_a | i_b;

endmodule

// File: rtl/rtype_alu_comb.sv
// rtype_alu_comb
// Purely combinational decode and compute for RV32I R-format operations.
// Ports:
//   i_rs1, i_rs2 : operand values
//   i_funct3     : instruction funct3
//   i_funct7     : instruction funct7
//   o_result     : computed result (0 for illegal encodings)
//   o_illegal    : funct3/funct7 pair is not a legal R-type op
module rtype_alu_comb
  import rtype_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [2:0]      i_funct3,
  input  logic [6:0]      i_funct7,
  output logic [XLEN-1:0] o_result,
  output logic            o_illegal
);

  op_e             w_op;
  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_or;
  logic [XLEN-1:0] w_and;
  logic            w_lt_signed;
  logic            w_lt_unsigned;

  assign w_op          = decode_op(i_funct3, i_funct7);
  // Shifts only ever look at the low five bits of rs2.
  assign w_shamt       = i_rs2[4:0];
  assign w_lt_signed   = ($signed(i_rs1) < $signed(i_rs2));
  assign w_lt_unsigned = (i_rs1 < i_rs2);

  or32_unit u_or (
    .i_a (i_rs1),
    .i_b (i_rs2),
    .o_y (w_or)
  );

  and32_unit u_and (
    .i_a (i_rs1),
    .i_b (i_rs2),
    .o_y (w_and)
  );

  always_comb begin
    o_result  = '0;
    o_illegal = 1'b0;
    case (w_op)
      OP_ADD:  o_result = i_rs1 + i_rs2;
      OP_SUB:  o_result = i_rs1 - i_rs2;
      OP_SLL:  o_result = i_rs1 << w_shamt;
      OP_SLT:  o_result = {{(XLEN-1){1'b0}}, w_lt_signed};
      OP_SLTU: o_result = {{(XLEN-1){1'b0}}, w_lt_unsigned};
      OP_XOR:  o_result = i_rs1 ^ i_rs2;
      OP_SRL:  o_result = i_rs1 >> w_shamt;
      OP_SRA:  o_result = $unsigned($signed(i_rs1) >>> w_shamt);
      OP_OR:   o_result = w_or;
      OP_AND:  o_result = w_and;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rtype_exec_stage.sv
// rtype_exec_stage
// Registered execute stage for RV32I R-format ops with a single-entry
// valid/ready pipeline register in front of writeback.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : upstream handshake
//   in_rs1, in_rs2      : operand values
//   in_funct3/in_funct7 : decoded funct fields
//   in_rd               : destination register index
//   out_valid/out_ready : writeback handshake
//   out_result, out_rd  : registered result and destination
//   out_illegal         : registered illegal-encoding flag
module rtype_exec_stage
  import rtype_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  state_e          r_state;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_rd;
  logic            r_illegal;

  logic [XLEN-1:0] w_alu_result;
  logic            w_alu_illegal;
  logic            w_accept;

  rtype_alu_comb #(.XLEN(XLEN)) u_alu (
    .i_rs1     (in_rs1),
    .i_rs2     (in_rs2),
    .i_funct3  (in_funct3),
    .i_funct7  (in_funct7),
    .o_result  (w_alu_result),
    .o_illegal (w_alu_illegal)
  );

  assign out_valid   = (r_state == ST_FULL);
  // A full register can still accept when writeback drains it this cycle.
  assign in_ready    = !out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign out_result  = r_result;
  assign out_rd      = r_rd;
  assign out_illegal = r_illegal;

  // Occupancy FSM plus data capture; data only loads on an input transfer,
  // so a stalled FULL entry keeps its outputs stable. Writes to x0 are
  // forced to a zero result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_EMPTY;
      r_result  <= '0;
      r_rd      <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) r_state <= ST_FULL;
        default:  if (out_ready && !w_accept) r_state <= ST_EMPTY;
      endcase
      if (w_accept) begin
        r_result  <= (in_rd == 5'd0) ? '0 : w_alu_result;
        r_rd      <= in_rd;
        r_illegal <= w_alu_illegal;
      end
    end
  end

endmodule

// File: tb/tb_rtype_exec_stage.sv
// tb_rtype_exec_stage
// Directed-vector bench: the driver pushes hand-computed expected results
// into a scoreboard queue on every accepted op, and a monitor pops and
// compares whenever the stage retires an op to writeback.
module tb_rtype_exec_stage;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        illegal;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal;

  exp_t sbQueue[$];
  int   checks = 0;
  int   errors = 0;

  rtype_exec_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_funct3   (in_funct3),
    .in_funct7   (in_funct7),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: every check bumps the counters printed at the end.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Present one op and hold it until the stage accepts it; the expected
  // response is queued at the moment of acceptance.
  task automatic applyStimulus(input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] rd, input logic [31:0] expResult,
                               input logic expIllegal);
    exp_t e;
    int   waited;
    in_valid  = 1'b1;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rd     = rd;
    #1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", {31'b0, in_ready}, 32'h1);
    end else begin
      e.result  = expResult;
      e.rd      = rd;
      e.illegal = expIllegal;
      sbQueue.push_back(e);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Monitor: a retire happens on the coming edge whenever valid and ready
  // are both high mid-cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_output", {31'b0, out_valid}, 32'h0);
      end else begin
        exp_t e;
        e = sbQueue.pop_front();
        checkOutput("sb_result", out_result, e.result);
        checkOutput("sb_rd", {27'b0, out_rd}, {27'b0, e.rd});
        checkOutput("sb_illegal", {31'b0, out_illegal}, {31'b0, e.illegal});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] held;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_rs1    = 32'h1;
    in_rs2    = 32'h2;
    in_funct3 = 3'b110;
    in_funct7 = 7'h00;
    in_rd     = 5'd5;

    // Reset and idle
    #12;
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("rst_out_result", out_result, 32'h0);
    checkOutput("rst_out_rd", {27'b0, out_rd}, 32'h0);
    checkOutput("rst_out_illegal", {31'b0, out_illegal}, 32'h0);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'h1, 32'h2, 3'b110, 7'h00, 5'd5, 32'h3, 1'b0);
    checkOutput("first_out_valid", {31'b0, out_valid}, 32'h1);

    // Arithmetic sweep
    applyStimulus(32'hFFFFFFFF, 32'h1,        3'b000, 7'h00, 5'd1, 32'h0,        1'b0);
    applyStimulus(32'h0,        32'h1,        3'b000, 7'h20, 5'd2, 32'hFFFFFFFF, 1'b0);
    applyStimulus(32'h80000000, 32'h1,        3'b010, 7'h00, 5'd3, 32'h1,        1'b0);
    applyStimulus(32'h80000000, 32'h1,        3'b011, 7'h00, 5'd4, 32'h0,        1'b0);
    applyStimulus(32'h80000000, 32'h21,       3'b101, 7'h20, 5'd5, 32'hC0000000, 1'b0);
    applyStimulus(32'h1,        32'd31,       3'b001, 7'h00, 5'd6, 32'h80000000, 1'b0);

    // Back-pressure: fill, then stall three cycles with a new op waiting
    @(negedge clk);
    #1;
    checkOutput("drain_before_bp", sbQueue.size(), 32'h0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(32'h55555555, 32'hAAAAAAAA, 3'b100, 7'h00, 5'd9, 32'hFFFFFFFF, 1'b0);
    in_valid  = 1'b1;
    in_rs1    = 32'h12345678;
    in_rs2    = 32'h0;
    in_funct3 = 3'b000;
    in_funct7 = 7'h00;
    in_rd     = 5'd10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_out_result", out_result, 32'hFFFFFFFF);
      checkOutput("bp_out_rd", {27'b0, out_rd}, 32'd9);
      checkOutput("bp_out_valid", {31'b0, out_valid}, 32'h1);
      checkOutput("bp_in_ready", {31'b0, in_ready}, 32'h0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(32'h12345678, 32'h0, 3'b000, 7'h00, 5'd10, 32'h12345678, 1'b0);
    checkOutput("bp_swap_out_valid", {31'b0, out_valid}, 32'h1);

    // Streaming: 8 back-to-back ops
    for (int i = 0; i < 8; i++) begin
      checkOutput("stream_in_ready", {31'b0, in_ready}, 32'h1);
      case (i)
        0: applyStimulus(32'd10,       32'd20,       3'b000, 7'h00, 5'd1, 32'h0000001E, 1'b0);
        1: applyStimulus(32'h100,      32'h1,        3'b000, 7'h20, 5'd2, 32'h000000FF, 1'b0);
        2: applyStimulus(32'hF0F0F0F0, 32'h0F0F0F0F, 3'b100, 7'h00, 5'd3, 32'hFFFFFFFF, 1'b0);
        3: applyStimulus(32'h00FF0000, 32'h000000FF, 3'b110, 7'h00, 5'd4, 32'h00FF00FF, 1'b0);
        4: applyStimulus(32'hFF00FF00, 32'h0FF00FF0, 3'b111, 7'h00, 5'd5, 32'h0F000F00, 1'b0);
        5: applyStimulus(32'h80000000, 32'h4,        3'b101, 7'h00, 5'd6, 32'h08000000, 1'b0);
        6: applyStimulus(32'hFFFFFFFF, 32'h0,        3'b010, 7'h00, 5'd7, 32'h1,        1'b0);
        default: applyStimulus(32'hFFFFFFFF, 32'h0,  3'b011, 7'h00, 5'd8, 32'h0,        1'b0);
      endcase
    end
    @(negedge clk);
    #1;
    checkOutput("stream_drained", sbQueue.size(), 32'h0);

    // Illegal encoding and x0 destination
    applyStimulus(32'h5, 32'h6, 3'b000, 7'h01, 5'd7, 32'h0, 1'b1);
    applyStimulus(32'h5, 32'h6, 3'b000, 7'h00, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("illegal_x0_drained", sbQueue.size(), 32'h0);

    // Reset mid-stall: the held op is dropped asynchronously
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(32'h7, 32'h8, 3'b000, 7'h00, 5'd11, 32'hF, 1'b0);
    @(negedge clk);
    held = out_result;
    checkOutput("stall_full", {31'b0, out_valid}, 32'h1);
    checkOutput("stall_result", held, 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("async_rst_in_ready", {31'b0, in_ready}, 32'h1);
    checkOutput("async_rst_out_result", out_result, 32'h0);
    sbQueue.delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    applyStimulus(32'h3, 32'h4, 3'b000, 7'h00, 5'd12, 32'h7, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("final_drained", sbQueue.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
